// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and helpers shared by the CPU datapath blocks.
//   DEFAULT_WIDTH : default datapath word width (32).
//   selIdx_t      : widest select index any mux in the datapath needs (up to 16 inputs).
//   selWidth()    : select-field width for an n-input mux (never below 1 bit).
package cpu_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int MAX_SEL_W     = 4;

  typedef logic [MAX_SEL_W-1:0] selIdx_t;

  function automatic int selWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: 2-entry valid/ready register pair (output slot + skid slot).
//   clk, reset            : clock, synchronous active-high reset
//   inValid/inReady/inData: upstream handshake; inReady depends only on state and reset
//   outValid/outReady/outData: downstream handshake, outData is registered
// The skid slot absorbs the one word accepted while the output slot is stalled,
// so inReady never combinationally depends on outReady.
module skid_buffer
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inData,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outData
);

  logic             skidValid;
  logic [WIDTH-1:0] skidData;
  logic             accept;
  logic             drain;

  assign inReady = !skidValid && !reset;
  assign accept  = inValid && inReady;
  // output slot is free to take a new word this cycle
  assign drain   = !outValid || outReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      outValid  <= 1'b0;
      outData   <= '0;
      skidValid <= 1'b0;
      skidData  <= '0;
    end else if (drain) begin
      if (skidValid) begin
        // inReady is low here, so no new word competes with the skid entry
        outData   <= skidData;
        outValid  <= 1'b1;
        skidValid <= 1'b0;
      end else if (accept) begin
        outData  <= inData;
        outValid <= 1'b1;
      end else begin
        outValid <= 1'b0;
      end
    end else if (accept) begin
      skidData  <= inData;
      skidValid <= 1'b1;
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: NUM_IN-way WIDTH-bit operand mux feeding a 2-entry skid buffer.
//   clk, reset      : clock, synchronous active-high reset
//   in_valid/in_ready, data_in (input k at [k*WIDTH +: WIDTH]), control_select
//   out_valid/out_ready, mux_out : registered selected word
//   sel_err         : sticky out-of-range select flag, present only with
//                     MUX_SEL_ERR_EN defined; cleared only by reset
// Out-of-range selects forward all-zeros.
module mux_n_pipe
  import cpu_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = selWidth(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]        control_select,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        mux_out
`ifdef MUX_SEL_ERR_EN
  ,
  output logic                    sel_err
`endif
);

  logic [NUM_IN-1:0][WIDTH-1:0] dataArr;
  logic [WIDTH-1:0]             selWord;
  selIdx_t                      selExt;

  for (genvar k = 0; k < NUM_IN; k++) begin : gUnpack
    assign dataArr[k] = data_in[k*WIDTH +: WIDTH];
  end

  assign selExt = selIdx_t'(control_select);

  // no input matches an out-of-range index, leaving the zero default
  always_comb begin
    selWord = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (selExt == selIdx_t'(k)) selWord = dataArr[k];
    end
  end

  skid_buffer #(.WIDTH(WIDTH)) uSkid (
    .clk      (clk),
    .reset    (reset),
    .inValid  (in_valid),
    .inReady  (in_ready),
    .inData   (selWord),
    .outValid (out_valid),
    .outReady (out_ready),
    .outData  (mux_out)
  );

`ifdef MUX_SEL_ERR_EN
  logic inRange;
  assign inRange = (32'(control_select) < 32'(NUM_IN));

  always_ff @(posedge clk) begin
    if (reset)                          sel_err <= 1'b0;
    else if (in_valid && in_ready && !inRange) sel_err <= 1'b1;
  end
`endif

endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
- Parametrised successor to the fixed 3-input, 32-bit datapath mux.
- Selects one of NUM_IN operand words of WIDTH bits and registers the result behind a valid/ready handshake.
- A 2-entry skid buffer lets the CPU datapath stall without combinational ready paths.
- Sits between register-file/forwarding sources and the ALU operand stage.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 3, number of selectable inputs (2..16).
- SEL_W, $clog2(NUM_IN) (minimum 1), width of the select field.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has a word to transfer.
- in_ready  output  1  block can accept a word this cycle.
- data_in  input  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- control_select  input  SEL_W  index of the input to forward.
- out_valid  output  1  mux_out holds a valid result.
- out_ready  input  1  downstream accepts mux_out this cycle.
- mux_out  output  WIDTH  registered selected word.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. On a reset edge: out_valid=0, skid_valid=0, mux_out=0, skid data=0. in_ready=0 while reset is high.
- Selection: computed combinationally at the input.
  - control_select < NUM_IN selects data_in[control_select*WIDTH +: WIDTH].
  - control_select >= NUM_IN selects all-zeros.
  - The result is captured only on accept, so later changes to data_in or control_select do not affect buffered words.
- Accept: accept = in_valid && in_ready; in_ready = !skid_valid && !reset (a register output, no combinational path from out_ready).
- Output stage, evaluated each cycle:
  - Output slot drains when (!out_valid || out_ready).
  - Output slot drains and skid_valid=1: the output loads skid data, skid_valid clears, and out_valid stays 1.
  - Output slot drains, skid empty, accept: the output loads the selected word and out_valid becomes 1.
  - Output slot drains, skid empty, no accept: out_valid becomes 0 and mux_out holds its last value.
  - Output slot stalled (out_valid && !out_ready) with accept: the word goes to the skid and skid_valid becomes 1.
- Latency: 1 cycle from accept to out_valid when not stalled. Full throughput is 1 word/cycle with out_ready held high.
- Boundary conditions:
  - Both entries full: in_ready=0 and upstream must hold.
  - Accept and drain in the same cycle pass data through with no bubble.
  - Ordering is strictly FIFO and no word is ever dropped or duplicated.
  - Reset mid-transfer discards both entries.

Optional Feature:
- Macro MUX_SEL_ERR_EN.
- Defined: adds output sel_err (1 bit). It is set sticky on any accepted word with control_select >= NUM_IN and is cleared only by reset (reset value 0).
- Undefined: no sel_err port. Out-of-range selects still yield zero with no indication.

Decomposition:
- Shared package (cpu_pkg): default WIDTH constant (32) and a select-index typedef helper.
- Natural sub-module: skid_buffer (2-entry valid/ready register pair, WIDTH-parametrised).
- mux_n_pipe instantiates skid_buffer after a combinational selector.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, mux_out=0; after release, in_ready=1.
- Select sweep: NUM_IN=3; inputs 0x11111111, 0x22222222, 0x33333333; control_select 0,1,2,3 with out_ready=1 -> mux_out 0x11111111, 0x22222222, 0x33333333, 0x00000000 on consecutive cycles, one cycle after each accept.
- Backpressure: out_ready=0 while sending A, then B -> out_valid=1 with A, B in skid, in_ready=0. Raise out_ready -> A, then B in order; in_ready returns to 1 one cycle after B moves to output.
- Streaming: 8 words, in_valid=1 and out_ready=1 continuously -> 8 consecutive out_valid cycles with no bubble.
- Reset mid-operation: both entries full, assert reset -> next cycle out_valid=0, skid empty, mux_out=0.
- MUX_SEL_ERR_EN defined: accept control_select=3 with NUM_IN=3 -> sel_err=1 and stays 1 after valid selects; reset -> 0.
